mem_wide_wr_narrow_rd: RTL and testbench

Parametrised dual-port buffer: wide write port A (byte-lane enables), narrow read port B with an auto-incrementing read pointer and a valid strobe. It sits between the 32-bit register/mailbox writer and the byte-serial IIC slave, so multi-byte IIC burst reads need no per-byte address from the host. It generalises the fixed 1Kx32-to-4Kx8 memory in width ratio, depth and lane masking, and adds read sequencing.

---
 rtl/mem_wn_pkg.sv | 21 ++
 rtl/mem_wide_wr_narrow_rd_sdp_ram_lane.sv | 37 +++
 rtl/mem_wide_wr_narrow_rd.sv | 153 +++++++++++++++
 tb/tb_mem_wide_wr_narrow_rd.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wn_pkg.sv
// mem_wn_pkg: shared constants and helpers for mem_wide_wr_narrow_rd.
//   DEF_*        default parameter values for the wide-write/narrow-read buffer
//   DEF_LSB/AWA/AWB  width constants derived from the defaults with $clog2
//   lane_offset  bit offset of a narrow lane inside a wide word
package mem_wn_pkg;

  localparam int DEF_WR_WIDTH = 32;
  localparam int DEF_RATIO    = 4;
  localparam int DEF_WR_DEPTH = 1024;
  localparam int DEF_RD_WIDTH = DEF_WR_WIDTH / DEF_RATIO;

  localparam int DEF_LSB = $clog2(DEF_RATIO);
  localparam int DEF_AWA = $clog2(DEF_WR_DEPTH);
  localparam int DEF_AWB = DEF_AWA + DEF_LSB;

  // Lane 0 sits in the least significant bits (little-endian layout).
  function automatic int lane_offset(input int lane, input int rd_width);
    return lane * rd_width;
  endfunction

endpackage

// File: rtl/mem_wide_wr_narrow_rd_sdp_ram_lane.sv
// sdp_ram_lane: one narrow lane of the buffer. Simple dual-port RAM with a
// single write port and one registered read port; a read and a write of the
// same address in one cycle return the pre-write contents (read-first).
// Contents are not reset.
//   clk    clock, rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata updates only when re is high
//   raddr  read address
//   rdata  registered read data
module sdp_ram_lane
  import mem_wn_pkg::*;
#(
  parameter int WIDTH = DEF_RD_WIDTH,
  parameter int DEPTH = DEF_WR_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both statements use non-blocking assignment, so a same-address read
  // samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_wide_wr_narrow_rd.sv
// mem_wide_wr_narrow_rd: wide-write / narrow-read buffer between a 32-bit
// register writer and a byte-serial IIC slave. Port A writes whole words with
// per-lane enables; port B reads one lane per request from an auto-incrementing
// pointer, with a fixed read latency of two cycles.
//
// Optional feature macro: MEM_RD_BYPASS_EN. When defined, a read that hits the
// word being written in the same cycle returns the newly written lanes
// (enabled lanes only); otherwise it returns pre-write data.
//
// Ports:
//   iClk        clock, rising edge
//   iRst_n      synchronous active-low reset
//   ivAddressA  port A word address
//   ivDataA     port A write data, lane i = [i*RD_WIDTH +: RD_WIDTH]
//   ivByteEnA   per-lane write enables
//   iWEA        write strobe
//   iLoadB      load read pointer from ivAddressB
//   ivAddressB  narrow start address
//   iRdReqB     read request, one narrow read per asserted cycle
//   ovDataB     read data, held until the next valid
//   oValidB     one-cycle pulse marking new ovDataB
//   ovPtrB      next narrow address to be read
//
// Port B handshake: there is no ready. Every cycle with iRdReqB high (outside
// reset) is accepted and produces exactly one oValidB pulse two cycles later.
module mem_wide_wr_narrow_rd
  import mem_wn_pkg::*;
#(
  parameter  int WR_WIDTH = DEF_WR_WIDTH,
  parameter  int RATIO    = DEF_RATIO,
  parameter  int WR_DEPTH = DEF_WR_DEPTH,
  localparam int RD_WIDTH = WR_WIDTH / RATIO,
  localparam int AWA      = $clog2(WR_DEPTH),
  localparam int LSB      = $clog2(RATIO),
  localparam int AWB      = AWA + LSB
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [AWA-1:0]      ivAddressA,
  input  logic [WR_WIDTH-1:0] ivDataA,
  input  logic [RATIO-1:0]    ivByteEnA,
  input  logic                iWEA,
  input  logic                iLoadB,
  input  logic [AWB-1:0]      ivAddressB,
  input  logic                iRdReqB,
  output logic [RD_WIDTH-1:0] ovDataB,
  output logic                oValidB,
  output logic [AWB-1:0]      ovPtrB
);

  logic [AWB-1:0]      ptr;
  logic [AWB-1:0]      rd_addr;
  logic [AWA-1:0]      rd_word;
  logic                rd_en;
  logic                wr_en;
  logic [WR_WIDTH-1:0] ram_q;
  logic [WR_WIDTH-1:0] merged;
  logic                v1;
  int                  lane_idx;
  logic [RD_WIDTH-1:0] lane_data;

  // A load in the same cycle as a request reads the loaded address directly.
  assign rd_addr = iLoadB ? ivAddressB : ptr;
  assign rd_word = rd_addr[AWB-1:LSB];
  assign rd_en   = iRdReqB & iRst_n;
  assign wr_en   = iWEA & iRst_n;
  assign ovPtrB  = ptr;

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    sdp_ram_lane #(
      .WIDTH (RD_WIDTH),
      .DEPTH (WR_DEPTH),
      .AW    (AWA)
    ) u_ram (
      .clk   (iClk),
      .we    (wr_en & ivByteEnA[g]),
      .waddr (ivAddressA),
      .wdata (ivDataA[g*RD_WIDTH +: RD_WIDTH]),
      .re    (rd_en),
      .raddr (rd_word),
      .rdata (ram_q[g*RD_WIDTH +: RD_WIDTH])
    );
  end

  // Pointer wraps naturally at 2^AWB.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      ptr <= '0;
    end else if (iRdReqB) begin
      ptr <= rd_addr + AWB'(1);
    end else if (iLoadB) begin
      ptr <= ivAddressB;
    end
  end

  // Lane index travels alongside the RAM output register.
  if (LSB > 0) begin : g_lane_sel
    logic [LSB-1:0] lane_q;
    always_ff @(posedge iClk) begin
      if (rd_en) lane_q <= rd_addr[LSB-1:0];
    end
    assign lane_idx = int'(lane_q);
  end else begin : g_no_lane_sel
    assign lane_idx = 0;
  end

`ifdef MEM_RD_BYPASS_EN
  logic                byp_hit;
  logic [RATIO-1:0]    byp_be;
  logic [WR_WIDTH-1:0] byp_data;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      byp_hit <= 1'b0;
    end else begin
      byp_hit <= rd_en & iWEA & (ivAddressA == rd_word);
    end
  end

  always_ff @(posedge iClk) begin
    if (rd_en) begin
      byp_be   <= ivByteEnA;
      byp_data <= ivDataA;
    end
  end

  // Substitute freshly written lanes over the read-first RAM output.
  always_comb begin
    merged = ram_q;
    for (int i = 0; i < RATIO; i++) begin
      if (byp_hit && byp_be[i]) merged[i*RD_WIDTH +: RD_WIDTH] = byp_data[i*RD_WIDTH +: RD_WIDTH];
    end
  end
`else
  assign merged = ram_q;
`endif

  assign lane_data = merged[lane_offset(lane_idx, RD_WIDTH) +: RD_WIDTH];

  // v1 marks a valid RAM output; clearing it on reset discards in-flight reads.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      v1      <= 1'b0;
      oValidB <= 1'b0;
      ovDataB <= '0;
    end else begin
      v1      <= iRdReqB;
      oValidB <= v1;
      if (v1) ovDataB <= lane_data;
    end
  end

endmodule

// File: tb/tb_mem_wide_wr_narrow_rd.sv
module tb_mem_wide_wr_narrow_rd;

  localparam int WW  = 32;
  localparam int R   = 4;
  localparam int RW  = 8;
  localparam int AWA = 10;
  localparam int AWB = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [AWA-1:0] addr_a;
  logic [WW-1:0]  data_a;
  logic [R-1:0]   be_a;
  logic           we_a;
  logic           load_b;
  logic [AWB-1:0] addr_b;
  logic           req_b;
  logic [RW-1:0]  data_b;
  logic           valid_b;
  logic [AWB-1:0] ptr_b;

  mem_wide_wr_narrow_rd dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .ivAddressA (addr_a),
    .ivDataA    (data_a),
    .ivByteEnA  (be_a),
    .iWEA       (we_a),
    .iLoadB     (load_b),
    .ivAddressB (addr_b),
    .iRdReqB    (req_b),
    .ovDataB    (data_b),
    .oValidB    (valid_b),
    .ovPtrB     (ptr_b)
  );

  int total = 0;
  int bad   = 0;
  int cnt   = 0;

  // ---------------- reference model state ----------------
  logic [RW-1:0]  mmem [R*1024];
  logic [AWB-1:0] mptr;
  logic [RW-1:0]  exp_last;
  logic [RW-1:0]  exp_q[$];
  int             due_q[$];

  typedef struct packed {
    logic           we;
    logic [AWA-1:0] aa;
    logic [WW-1:0]  da;
    logic [R-1:0]   be;
    logic           ld;
    logic [AWB-1:0] ab;
    logic           rq;
    logic           ev;
    logic [RW-1:0]  ed;
    logic [AWB-1:0] ep;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic we, input int aa, input logic [WW-1:0] da,
                              input logic [R-1:0] be, input logic ld, input int ab,
                              input logic rq, input logic ev, input logic [RW-1:0] ed,
                              input int ep);
    vec_t v;
    v.we = we; v.aa = AWA'(aa); v.da = da; v.be = be;
    v.ld = ld; v.ab = AWB'(ab); v.rq = rq;
    v.ev = ev; v.ed = ed; v.ep = AWB'(ep);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AWA-1:0] aa, input logic [WW-1:0] da,
                       input logic [R-1:0] be, input logic ld, input logic [AWB-1:0] ab,
                       input logic rq);
    we_a = we; addr_a = aa; data_a = da; be_a = be;
    load_b = ld; addr_b = ab; req_b = rq;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle against the behavioural model: a narrow address n lives in
  // word n/R, lane n%R; reads see memory before this cycle's write unless
  // same-cycle forwarding is built in.
  task automatic mcyc(input logic we, input logic [AWA-1:0] aa, input logic [WW-1:0] da,
                      input logic [R-1:0] be, input logic ld, input logic [AWB-1:0] ab,
                      input logic rq);
    int na;
    logic [RW-1:0] val;
    logic ev;
    drive(we, aa, da, be, ld, ab, rq);
    if (rq) begin
      na  = ld ? int'(ab) : int'(mptr);
      val = mmem[na];
`ifdef MEM_RD_BYPASS_EN
      if (we && int'(aa) == na / R && be[na % R]) val = da[RW*(na % R) +: RW];
`endif
      exp_q.push_back(val);
      due_q.push_back(cnt + 2);
      mptr = AWB'((na + 1) % (R*1024));
    end else if (ld) begin
      mptr = ab;
    end
    if (we) begin
      for (int i = 0; i < R; i++) if (be[i]) mmem[int'(aa)*R + i] = da[RW*i +: RW];
    end
    step();
    cnt++;
    ev = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cnt) begin
      ev = 1'b1;
      void'(due_q.pop_front());
      exp_last = exp_q.pop_front();
    end
    chk("m_valid", 32'(valid_b), 32'(ev));
    chk("m_data",  32'(data_b),  32'(exp_last));
    chk("m_ptr",   32'(ptr_b),   32'(mptr));
  endtask

  task automatic mreset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), AWA'($urandom), $urandom, R'($urandom), 1'($urandom),
            AWB'($urandom), 1'b1);
      step();
      chk("mrst_valid", 32'(valid_b), 32'd0);
      chk("mrst_data",  32'(data_b),  32'd0);
    end
    due_q.delete();
    exp_q.delete();
    mptr     = '0;
    exp_last = '0;
    rst_n    = 1'b1;
    drive(0, '0, '0, '0, 0, '0, 0);
  endtask

  logic           r_we, r_ld, r_rq;
  logic [AWA-1:0] r_aa;
  logic [AWB-1:0] r_ab;

  initial begin
    logic [RW-1:0] coll_exp;
`ifdef MEM_RD_BYPASS_EN
    coll_exp = 8'h88;
`else
    coll_exp = 8'h44;
`endif
    //          we aa    da            be   ld ab    rq  ev ed     ep
    tbl[0]  = mk(1, 5,    32'hA1B2C3D4, 4'hF, 0, 0,    0,  0, 8'h00, 0);
    tbl[1]  = mk(0, 0,    32'h0,        4'h0, 1, 20,   0,  0, 8'h00, 20);
    tbl[2]  = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  0, 8'h00, 21);
    tbl[3]  = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'hD4, 22);
    tbl[4]  = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'hC3, 23);
    tbl[5]  = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'hB2, 24);
    tbl[6]  = mk(0, 0,    32'h0,        4'h0, 0, 0,    0,  1, 8'hA1, 24);
    tbl[7]  = mk(0, 0,    32'h0,        4'h0, 0, 0,    0,  0, 8'hA1, 24);
    tbl[8]  = mk(1, 5,    32'hFFFFFFFF, 4'h4, 0, 0,    0,  0, 8'hA1, 24);
    tbl[9]  = mk(0, 0,    32'h0,        4'h0, 1, 20,   1,  0, 8'hA1, 21);
    tbl[10] = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'hD4, 22);
    tbl[11] = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'hC3, 23);
    tbl[12] = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'hFF, 24);
    tbl[13] = mk(0, 0,    32'h0,        4'h0, 0, 0,    0,  1, 8'hA1, 24);
    tbl[14] = mk(1, 1023, 32'h5A000000, 4'hF, 0, 0,    0,  0, 8'hA1, 24);
    tbl[15] = mk(1, 0,    32'h0000003C, 4'h1, 0, 0,    0,  0, 8'hA1, 24);
    tbl[16] = mk(0, 0,    32'h0,        4'h0, 1, 4095, 0,  0, 8'hA1, 4095);
    tbl[17] = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  0, 8'hA1, 0);
    tbl[18] = mk(0, 0,    32'h0,        4'h0, 0, 0,    1,  1, 8'h5A, 1);
    tbl[19] = mk(0, 0,    32'h0,        4'h0, 0, 0,    0,  1, 8'h3C, 1);
    tbl[20] = mk(1, 3,    32'h11223344, 4'hF, 0, 0,    0,  0, 8'h3C, 1);
    tbl[21] = mk(1, 3,    32'h55667788, 4'hF, 1, 12,   1,  0, 8'h3C, 13);
    tbl[22] = mk(0, 0,    32'h0,        4'h0, 1, 12,   1,  1, coll_exp, 13);
    tbl[23] = mk(0, 0,    32'h0,        4'h0, 0, 0,    0,  1, 8'h88, 13);
    tbl[24] = mk(0, 0,    32'h0,        4'h0, 0, 0,    0,  0, 8'h88, 13);

    // ---- reset with requests and writes held high ----
    rst_n = 1'b0;
    drive(1, AWA'(7), 32'hDEADBEEF, 4'hF, 1, AWB'(100), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", 32'(valid_b), 32'd0);
    end
    rst_n = 1'b1;
    drive(0, '0, '0, '0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", 32'(valid_b), 32'd0);
      chk("idle_data",  32'(data_b),  32'd0);
      chk("idle_ptr",   32'(ptr_b),   32'd0);
    end

    // ---- directed vectors ----
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].we, tbl[i].aa, tbl[i].da, tbl[i].be, tbl[i].ld, tbl[i].ab, tbl[i].rq);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(valid_b), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i),  32'(data_b),  32'(tbl[i].ed));
      chk($sformatf("vec%0d_ptr", i),   32'(ptr_b),   32'(tbl[i].ep));
    end

    // ---- reset one cycle after a read request ----
    drive(0, '0, '0, '0, 0, '0, 1);
    step();
    chk("midrst_ptr_pre", 32'(ptr_b), 32'd14);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(valid_b), 32'd0);
    rst_n = 1'b1;
    drive(0, '0, '0, '0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_post_valid", 32'(valid_b), 32'd0);
      chk("midrst_post_ptr",   32'(ptr_b),   32'd0);
      chk("midrst_post_data",  32'(data_b),  32'd0);
    end

    // ---- randomized phase against the model ----
    mptr     = '0;
    exp_last = '0;
    for (int w = 0; w < 1024; w++) mcyc(1, AWA'(w), $urandom, 4'hF, 0, '0, 0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) mreset();
      r_we = ($urandom_range(0, 9) < 4);
      r_aa = ($urandom_range(0, 1) == 1) ? AWA'($urandom_range(0, 3)) : AWA'($urandom);
      r_ld = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 2))
        0:       r_ab = AWB'($urandom_range(0, 15));
        1:       r_ab = AWB'($urandom_range(4088, 4095));
        default: r_ab = AWB'($urandom);
      endcase
      r_rq = ($urandom_range(0, 9) < 7);
      mcyc(r_we, r_aa, $urandom, R'($urandom), r_ld, r_ab, r_rq);
    end

    // drain
    for (int i = 0; i < 3; i++) mcyc(0, '0, '0, '0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
